// File: rtl/dpram_pkg.sv
// Shared defaults and FSM state encoding for the dual-port RAM burst streamer.
package dpram_pkg;

  localparam int ADDR_W = 8;
  localparam int DAT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dpram_skid_fifo.sv
// Two-entry output buffer for the streamer; push and pop may occur in the same cycle.
module dpram_skid_fifo #(
  parameter int DAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [DAT_W-1:0] din,
  input  logic             pop,
  output logic [DAT_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [DAT_W-1:0] mem_q [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign dout    = mem_q[rptr_q];
  assign pop_ok  = pop & ~empty;
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push_ok) wptr_d = ~wptr_q;
      if (pop_ok)  rptr_d = ~rptr_q;
      cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok && !flush) mem_q[wptr_q] <= din;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/dpram_streamer.sv
// Streams a burst of words from the second port of a dual-port RAM onto a ready/valid bus.
// Optional m_last output is built when DPRAM_STREAMER_LAST_EN is defined.
module dpram_streamer
  import dpram_pkg::*;
#(
  parameter int ADDR_W = dpram_pkg::ADDR_W,
  parameter int DAT_W  = dpram_pkg::DAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DAT_W-1:0]  ram_dat,
  output logic [DAT_W-1:0]  m_dat,
  output logic              m_valid,
`ifdef DPRAM_STREAMER_LAST_EN
  output logic              m_last,
`endif
  input  logic              m_ready
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic              infl_q, infl_d;
  logic              done_q, done_d;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        eff_occ;

  assign pop      = m_valid & m_ready;
  assign occ      = fifo_full ? 2'd2 : {1'b0, ~fifo_empty};
  // Slots still committed after this cycle: a word leaving now frees room for a new read.
  assign eff_occ  = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};
  assign ram_addr = addr_q;
  assign done     = done_q;
  assign m_valid  = ~fifo_empty;

`ifdef DPRAM_STREAMER_LAST_EN
  assign m_last = m_valid & (out_cnt_q == ONE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && length != '0)     state_d = ST_READ;
        ST_READ:  if (ram_rd && rd_cnt_q == ONE) state_d = ST_DRAIN;
        ST_DRAIN: if (pop && out_cnt_q == ONE)   state_d = ST_IDLE;
        default:                                 state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    ram_rd = (state_q == ST_READ) && !abort && (eff_occ < 3'd2);
  end

  always_comb begin
    addr_d    = addr_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    infl_d    = ram_rd;
    done_d    = 1'b0;
    if (abort) begin
      infl_d    = 1'b0;
      rd_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        if (length != '0) begin
          addr_d    = base_addr;
          rd_cnt_d  = length;
          out_cnt_d = length;
        end else begin
          done_d = 1'b1;
        end
      end
      if (ram_rd) begin
        addr_d   = addr_q + ONE;
        rd_cnt_d = rd_cnt_q - ONE;
      end
      if (pop) begin
        out_cnt_d = out_cnt_q - ONE;
        if (state_q == ST_DRAIN && out_cnt_q == ONE) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      infl_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      infl_q    <= infl_d;
      done_q    <= done_d;
    end
  end

  // RAM data is valid the cycle after each read, so the in-flight flag is the push strobe.
  dpram_skid_fifo #(
    .DAT_W (DAT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (infl_q),
    .din   (ram_dat),
    .pop   (pop),
    .dout  (m_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
